// File: rtl/minaret_bus_arbiter.sv
// minaret_bus_arbiter: two-master round-robin arbiter sharing the minaret data-bus slave port.
// Define MINARET_ARB_TIMEOUT_EN to add the forced-abort watchdog and sticky err flag.
module minaret_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wmask,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wmask,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wmask,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hdeadbeef;

  state_e state_q;
  logic   owner_q;
  logic   prio_q;
  logic   busy_s;
  logic   owner_valid_s;
  logic   done_s;
  logic   timeout_s;

  assign busy_s        = (state_q == ST_BUSY);
  assign owner_valid_s = owner_q ? m1_valid : m0_valid;
  assign done_s        = busy_s && owner_valid_s && s_ready;

`ifdef MINARET_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // A timeout only fires on a still-requesting owner the slave has not answered.
  assign timeout_s = busy_s && owner_valid_s && !s_ready && (cnt_q == CNT_LAST);
  assign err       = err_q;

  // Watchdog next state: counter held at zero outside BUSY so entry starts it cleared
  always_comb begin
    if (!busy_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (done_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
    err_d = err_q | timeout_s;
  end

  // Watchdog state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_cfg_s;

  assign timeout_s    = 1'b0;
  assign err          = 1'b0;
  assign unused_cfg_s = ^{TIMEOUT_CYCLES, CNT_W};
`endif

  // Arbitration FSM: grant in IDLE, release on completion, abandon or timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_valid || m1_valid) begin
            state_q <= ST_BUSY;
            owner_q <= (m0_valid && m1_valid) ? prio_q : m1_valid;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (done_s) begin
            state_q <= ST_IDLE;
            prio_q  <= ~owner_q;
          end else if (!owner_valid_s) begin
            state_q <= ST_IDLE;
          end else if (timeout_s) begin
            state_q <= ST_IDLE;
            prio_q  <= ~prio_q;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Slave-side request mux and per-master completion/readback
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = 32'h0000_0000;
    s_wmask  = 4'h0;
    s_wdata  = 32'h0000_0000;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
    if (busy_s) begin
      s_valid = owner_valid_s && !timeout_s;
      if (owner_q) begin
        s_addr   = m1_addr;
        s_wmask  = m1_wmask;
        s_wdata  = m1_wdata;
        m1_ready = done_s || timeout_s;
        m1_rdata = timeout_s ? TIMEOUT_RDATA : s_rdata;
      end else begin
        s_addr   = m0_addr;
        s_wmask  = m0_wmask;
        s_wdata  = m0_wdata;
        m0_ready = done_s || timeout_s;
        m0_rdata = timeout_s ? TIMEOUT_RDATA : s_rdata;
      end
    end else begin
      s_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_minaret_bus_arbiter.sv
// Bench for minaret_bus_arbiter: directed scenarios plus randomized masters/slave,
// all checked every cycle against a transaction-level model of the arbitration rules.
module tb_minaret_bus_arbiter;

`ifdef MINARET_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int TCYC  = 16;
  localparam int CW    = 5;
`else
  localparam bit TO_EN = 1'b0;
  localparam int TCYC  = 256;
  localparam int CW    = 9;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mv [2];
  logic [31:0] ma [2];
  logic [3:0]  mm [2];
  logic [31:0] md [2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        err;

  int checks = 0;
  int errors = 0;

  // model of the arbiter: grant holder, round-robin pointer, stall count, sticky error
  bit b_busy  = 1'b0;
  int b_owner = 0;
  int b_prio  = 0;
  int b_cnt   = 0;
  bit b_err   = 1'b0;

  always #5 clk = ~clk;

  minaret_bus_arbiter #(.TIMEOUT_CYCLES(TCYC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_addr(ma[0]), .m0_wmask(mm[0]),
    .m0_wdata(md[0]), .m0_rdata(m0_rdata),
    .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_addr(ma[1]), .m1_wmask(mm[1]),
    .m1_wdata(md[1]), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wmask(s_wmask),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mv[0] = 1'b0;
    mv[1] = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  // per-cycle compare against the model, then advance the model by one clock
  always @(negedge clk) begin
    logic [135:0] exp_v, act_v;
    logic [31:0]  e_addr, e_wdata, e_rd0, e_rd1;
    logic [3:0]   e_wmask;
    logic         e_sv, e_r0, e_r1, e_err;
    bit           ov, fin, tmo;
    e_sv = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
    e_addr = 32'h0; e_wmask = 4'h0; e_wdata = 32'h0;
    e_rd0 = s_rdata; e_rd1 = s_rdata;
    ov = 1'b0; fin = 1'b0; tmo = 1'b0;
    if (reset) begin
      b_busy = 1'b0; b_owner = 0; b_prio = 0; b_cnt = 0; b_err = 1'b0;
    end else if (b_busy) begin
      ov  = mv[b_owner];
      fin = ov && s_ready;
      tmo = TO_EN && ov && !s_ready && (b_cnt == TCYC - 1);
      e_sv    = ov && !tmo;
      e_addr  = ma[b_owner];
      e_wmask = mm[b_owner];
      e_wdata = md[b_owner];
      if (fin || tmo) begin
        if (b_owner == 0) e_r0 = 1'b1;
        else e_r1 = 1'b1;
      end
      if (tmo) begin
        if (b_owner == 0) e_rd0 = 32'hdeadbeef;
        else e_rd1 = 32'hdeadbeef;
      end
    end
    e_err = b_err;
    exp_v = {e_sv, e_r0, e_r1, e_err, e_addr, e_wmask, e_wdata, e_rd0, e_rd1};
    act_v = {s_valid, m0_ready, m1_ready, err, s_addr, s_wmask, s_wdata, m0_rdata, m1_rdata};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t actual=%0h expected=%0h", $time, act_v, exp_v);
    end
    if (!reset) begin
      if (!b_busy) begin
        if (mv[0] || mv[1]) begin
          b_busy  = 1'b1;
          b_owner = (mv[0] && mv[1]) ? b_prio : (mv[0] ? 0 : 1);
          b_cnt   = 0;
        end
      end else if (fin) begin
        b_busy = 1'b0;
        b_prio = 1 - b_owner;
      end else if (!ov) begin
        b_busy = 1'b0;
      end else if (tmo) begin
        b_busy = 1'b0;
        b_prio = 1 - b_prio;
        b_err  = 1'b1;
      end else begin
        b_cnt++;
      end
    end
  end

  initial begin
    logic rdy_prev [2];
    bit   seen;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = 32'h0; mm[i] = 4'h0; md[i] = 32'h0; rdy_prev[i] = 1'b0;
    end
    s_ready = 1'b0;
    s_rdata = 32'h0;
    cyc(); cyc();
    #2;
    check("rst_svalid", s_valid, 64'd0);
    check("rst_m0ready", m0_ready, 64'd0);
    check("rst_m1ready", m1_ready, 64'd0);
    check("rst_saddr", {s_addr, s_wdata}, 64'd0);
    check("rst_swmask", s_wmask, 64'd0);
    check("rst_err", err, 64'd0);
    cyc();
    reset = 1'b0;

    // single read from m0
    mv[0] = 1'b1; ma[0] = 32'h100; mm[0] = 4'h0; md[0] = 32'h0;
    s_ready = 1'b1; s_rdata = 32'h12345678;
    #2 check("t1_c0_svalid", s_valid, 64'd0);
    cyc();
    #2;
    check("t1_c1_svalid", s_valid, 64'd1);
    check("t1_c1_saddr", s_addr, 64'h100);
    check("t1_c1_m0ready", m0_ready, 64'd1);
    check("t1_c1_m0rdata", m0_rdata, 64'h12345678);
    cyc();
    mv[0] = 1'b0;
    #2 check("t1_c2_svalid", s_valid, 64'd0);
    cyc();

    // both masters continuously requesting
    do_reset();
    mv[0] = 1'b1; ma[0] = 32'h1000; mv[1] = 1'b1; ma[1] = 32'h2000; s_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      check("t2_m0ready", m0_ready, ((c % 4) == 1) ? 64'd1 : 64'd0);
      check("t2_m1ready", m1_ready, ((c % 4) == 3) ? 64'd1 : 64'd0);
      cyc();
    end
    mv[0] = 1'b0; mv[1] = 1'b0;

    // m1 write stalled by slave while m0 waits
    do_reset();
    s_ready = 1'b0;
    mv[1] = 1'b1; ma[1] = 32'h200; mm[1] = 4'b0011; md[1] = 32'haabbccdd;
    ma[0] = 32'h300; mm[0] = 4'h0;
    #2 check("t3_c0_svalid", s_valid, 64'd0);
    cyc();
    mv[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #2;
      check("t3_stall_sreq", {s_valid, s_wmask, s_addr}, {27'd0, 1'b1, 4'b0011, 32'h200});
      check("t3_stall_wdata", s_wdata, 64'haabbccdd);
      check("t3_stall_readys", {m0_ready, m1_ready}, 64'd0);
      cyc();
    end
    s_ready = 1'b1;
    #2 check("t3_c6_readys", {m0_ready, m1_ready}, 64'd1);
    cyc();
    mv[1] = 1'b0;
    #2 check("t3_c7_svalid", s_valid, 64'd0);
    cyc();
    #2;
    check("t3_c8_saddr", s_addr, 64'h300);
    check("t3_c8_m0ready", m0_ready, 64'd1);
    cyc();
    mv[0] = 1'b0;

    // m0 abandons on the third BUSY cycle
    do_reset();
    s_ready = 1'b0;
    mv[0] = 1'b1; ma[0] = 32'h400; ma[1] = 32'h500;
    cyc(); cyc(); cyc();
    mv[0] = 1'b0;
    #2 check("t4_abandon", {s_valid, m0_ready}, 64'd0);
    cyc();
    mv[0] = 1'b1; mv[1] = 1'b1; s_ready = 1'b1;
    #2 check("t4_idle_svalid", s_valid, 64'd0);
    cyc();
    #2 check("t4_prio_kept", {s_valid, m0_ready, s_addr}, {30'd0, 1'b1, 1'b1, 32'h400});
    cyc();
    mv[0] = 1'b0; mv[1] = 1'b0;

    // reset mid-transfer
    do_reset();
    s_ready = 1'b0;
    mv[0] = 1'b1; ma[0] = 32'h600;
    cyc(); cyc();
    reset = 1'b1;
    #2 check("t5_rst_outs", {s_valid, m0_ready, m1_ready, err}, 64'd0);
    cyc();
    reset = 1'b0; mv[1] = 1'b1; ma[1] = 32'h700;
    #2 check("t5_rel_svalid", s_valid, 64'd0);
    cyc();
    #2 check("t5_first_grant", {s_valid, s_addr}, {31'd0, 1'b1, 32'h600});
    cyc();
    mv[0] = 1'b0; mv[1] = 1'b0;

    // unanswered request: watchdog abort or indefinite wait
    do_reset();
    s_ready = 1'b0; s_rdata = 32'h5555aaaa;
    mv[0] = 1'b1; ma[0] = 32'h800;
    cyc();
    seen = 1'b0;
`ifdef MINARET_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      #2 if (m0_ready) seen = 1'b1;
      cyc();
    end
    check("t6_no_early_ready", seen, 64'd0);
    #2;
    check("t6_to_ready", {s_valid, m0_ready, err}, 64'b010);
    check("t6_to_rdata", m0_rdata, 64'hdeadbeef);
    cyc();
    mv[0] = 1'b0;
    #2 check("t6_err_set", err, 64'd1);
    cyc(); cyc();
    #2 check("t6_err_sticky", err, 64'd1);
    cyc();
`else
    for (int k = 1; k <= 100; k++) begin
      #2 if (m0_ready || err) seen = 1'b1;
      cyc();
    end
    check("t6_no_ready_no_err", seen, 64'd0);
    #2 check("t6_still_busy", s_valid, 64'd1);
    cyc();
    mv[0] = 1'b0;
    cyc();
`endif

    // randomized traffic: protocol-following masters, random slave
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && rdy_prev[i]) begin
          mv[i] = 1'b0;
        end else if (mv[i] && ($urandom_range(0, 39) == 0)) begin
          mv[i] = 1'b0;
        end else if (!mv[i] && ($urandom_range(0, 2) == 0)) begin
          mv[i] = 1'b1;
          ma[i] = $urandom;
          mm[i] = 4'($urandom_range(0, 15));
          md[i] = $urandom;
        end
      end
      s_ready = ($urandom_range(0, 1) == 1);
      s_rdata = $urandom;
      reset   = ($urandom_range(0, 299) == 0);
      #7;
      rdy_prev[0] = m0_ready;
      rdy_prev[1] = m1_ready;
      cyc();
    end
    reset = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
